// File: rtl/regbank_access_arbiter.sv
// Two-requester access arbiter for a shared bank of tri-state-output registers.
// Requester 0 is CPU writeback, requester 1 is the debug/loader port. One
// transfer is in flight at a time; contention is resolved round-robin, and the
// FSM only advances on cycles where the global Tick enable is high.
module regbank_access_arbiter #(
   parameter int unsigned NrOfBits = 32,
   parameter int unsigned NrOfRegs = 8,
   parameter int unsigned AddrBits = 3
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                Tick,
   input  logic [1:0]          req,
   input  logic [1:0]          we,
   input  logic [AddrBits-1:0] addr0,
   input  logic [AddrBits-1:0] addr1,
   input  logic [NrOfBits-1:0] wdata0,
   input  logic [NrOfBits-1:0] wdata1,
   input  logic [NrOfBits-1:0] bus_Q,
   output logic [1:0]          ack,
   output logic [NrOfBits-1:0] rdata,
   output logic                err,
   output logic [NrOfBits-1:0] bus_D,
   output logic [NrOfRegs-1:0] reg_ce,
   output logic [NrOfRegs-1:0] reg_cs,
   output logic                busy
);

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      RD_SEL,
      RD_CAP,
      DONE
   } state_t;

   state_t                state_q, state_d;
   logic                  ptr_q, ptr_d;
   logic                  id_q, id_d;
   logic                  we_q, we_d;
   logic [AddrBits-1:0]   addr_q, addr_d;
   logic [NrOfBits-1:0]   wdata_q, wdata_d;
   logic [NrOfBits-1:0]   rdata_q, rdata_d;
   logic                  gnt;
   logic                  in_range;

   assign in_range = ({1'b0, addr_q} < (AddrBits + 1)'(NrOfRegs));

   // Next-state, grant/latch and completion-pulse logic; nothing moves unless Tick=1.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      gnt     = 1'b0;
      ack     = '0;
      err     = 1'b0;
      case (state_q)
         IDLE: begin
            if (Tick && (req != 2'b00)) begin
               // Pointer only matters under contention; a lone requester always wins.
               gnt     = (req == 2'b11) ? ptr_q : req[1];
               id_d    = gnt;
               we_d    = we[gnt];
               addr_d  = gnt ? addr1 : addr0;
               wdata_d = gnt ? wdata1 : wdata0;
               state_d = we[gnt] ? WRITE : RD_SEL;
            end
         end
         WRITE: begin
            if (Tick) state_d = DONE;
         end
         RD_SEL: begin
            if (Tick) state_d = RD_CAP;
         end
         RD_CAP: begin
            if (Tick) begin
               rdata_d = in_range ? bus_Q : '0;
               state_d = DONE;
            end
         end
         DONE: begin
            if (Tick) begin
               ack[id_q] = 1'b1;
               err       = ~in_range;
               ptr_d     = ~id_q;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Register-bank strobes: write enable only in WRITE, single cs-low only while reading.
   always_comb begin
      reg_ce = '0;
      reg_cs = '1;
      for (int unsigned i = 0; i < NrOfRegs; i++) begin
         if (addr_q == AddrBits'(i)) begin
            reg_ce[i] = (state_q == WRITE);
            reg_cs[i] = ~((state_q == RD_SEL) || (state_q == RD_CAP));
         end
      end
   end

   // State and latched-transfer registers with synchronous active-low reset.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_q <= IDLE;
         ptr_q   <= 1'b0;
         id_q    <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;
   assign bus_D = wdata_q;
   assign busy  = (state_q != IDLE);

   // Latched op is kept for debug visibility alongside the other transfer fields.
   logic unused_we;
   assign unused_we = we_q;

endmodule

// File: tb/tb_regbank_access_arbiter.sv
// Directed-vector bench for regbank_access_arbiter with a behavioural
// register bank driving the shared read bus.
module tb_regbank_access_arbiter;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        Tick;
   logic [1:0]  req;
   logic [1:0]  we;
   logic [3:0]  addr0, addr1;
   logic [31:0] wdata0, wdata1;
   logic [31:0] bus_Q;
   logic [1:0]  ack;
   logic [31:0] rdata;
   logic        err;
   logic [31:0] bus_D;
   logic [7:0]  reg_ce;
   logic [7:0]  reg_cs;
   logic        busy;

   logic [31:0] bank [8];

   int n_vec = 0;
   int n_err = 0;
   int inv_bad = 0;

   regbank_access_arbiter #(
      .NrOfBits(32),
      .NrOfRegs(8),
      .AddrBits(4)
   ) dut (
      .Clock(Clock), .Reset(Reset), .Tick(Tick),
      .req(req), .we(we), .addr0(addr0), .addr1(addr1),
      .wdata0(wdata0), .wdata1(wdata1), .bus_Q(bus_Q),
      .ack(ack), .rdata(rdata), .err(err), .bus_D(bus_D),
      .reg_ce(reg_ce), .reg_cs(reg_cs), .busy(busy)
   );

   always #5 Clock = ~Clock;

   // Register bank: captures bus_D on its enable, drives bus_Q when selected.
   always_ff @(posedge Clock) begin
      for (int i = 0; i < 8; i++)
         if (reg_ce[i]) bank[i] <= bus_D;
   end

   always_comb begin
      bus_Q = 32'h0;
      for (int i = 0; i < 8; i++)
         if (!reg_cs[i]) bus_Q = bank[i];
   end

   // Single-driver and no-write-during-read invariants, sampled mid-cycle.
   always @(negedge Clock) begin
      #2;
      if (Reset === 1'b1) begin
         if (($countones(reg_ce) > 1) || ($countones(~reg_cs) > 1) ||
             ((reg_ce & ~reg_cs) != 8'h00))
            inv_bad++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(negedge Clock);
   endtask

   task automatic start(input int id, input logic w, input logic [3:0] a, input logic [31:0] d);
      cyc();
      req[id] = 1'b1;
      we[id]  = w;
      if (id == 0) begin addr0 = a; wdata0 = d; end
      else begin addr1 = a; wdata1 = d; end
      #1;
   endtask

   // Waits (bounded) for an ack pulse; lat is cycles after the grant edge, 0 on timeout.
   task automatic wait_ack(input bit alt, output int lat, output logic [7:0] cs_low,
                           output logic [7:0] ce_seen, output int ce_cycles);
      lat = 0; cs_low = '0; ce_seen = '0; ce_cycles = 0;
      for (int k = 1; k <= 20; k++) begin
         cyc();
         if (alt) Tick = (k % 2 == 0);
         #1;
         cs_low  |= ~reg_cs;
         ce_seen |= reg_ce;
         if (reg_ce != 8'h00) ce_cycles++;
         if (ack != 2'b00) begin
            lat = k;
            break;
         end
      end
   endtask

   int          lat, ce_cycles, n_ack;
   logic [7:0]  cs_low, ce_seen;
   logic [1:0]  order [4];

   initial begin
      Reset = 1'b0; Tick = 1'b1; req = '0; we = '0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      for (int i = 0; i < 8; i++) bank[i] = 32'h0;
      repeat (3) cyc();
      #1;
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_cs", 32'(reg_cs), 32'hFF);
      chk("rst_ce", 32'(reg_ce), 32'h00);
      chk("rst_busD", bus_D, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_ack", 32'(ack), 32'h0);
      Reset = 1'b1;

      // Write 0xDEADBEEF to reg 3 through requester 0.
      start(0, 1'b1, 4'd3, 32'hDEADBEEF);
      chk("w_idle_busy", 32'(busy), 32'h0);
      wait_ack(1'b0, lat, cs_low, ce_seen, ce_cycles);
      chk("w_lat", 32'(lat), 32'd2);
      chk("w_ack", 32'(ack), 32'h1);
      chk("w_err", 32'(err), 32'h0);
      chk("w_ce_onehot", 32'(ce_seen), 32'h08);
      chk("w_ce_cycles", 32'(ce_cycles), 32'd1);
      chk("w_no_cs", 32'(cs_low), 32'h00);
      chk("w_busD", bus_D, 32'hDEADBEEF);
      req = 2'b00;

      // Read reg 3 back through requester 1.
      start(1, 1'b0, 4'd3, 32'h0);
      wait_ack(1'b0, lat, cs_low, ce_seen, ce_cycles);
      chk("r_lat", 32'(lat), 32'd3);
      chk("r_ack", 32'(ack), 32'h2);
      chk("r_rdata", rdata, 32'hDEADBEEF);
      chk("r_cs_low", 32'(cs_low), 32'h08);
      chk("r_no_ce", 32'(ce_seen), 32'h00);
      chk("r_cs_done", 32'(reg_cs), 32'hFF);
      req = 2'b00;

      // Both requesters writing continuously: strict alternation from requester 0.
      cyc();
      req = 2'b11; we = 2'b11;
      addr0 = 4'd1; wdata0 = 32'h11; addr1 = 4'd2; wdata1 = 32'h22;
      #1;
      n_ack = 0;
      for (int k = 1; k <= 12; k++) begin
         cyc(); #1;
         if (ack != 2'b00) begin
            if (n_ack < 4) order[n_ack] = ack;
            n_ack++;
         end
         if (k == 12) req = 2'b00;
      end
      chk("rr_count", 32'(n_ack), 32'd4);
      chk("rr_0", 32'(order[0]), 32'h1);
      chk("rr_1", 32'(order[1]), 32'h2);
      chk("rr_2", 32'(order[2]), 32'h1);
      chk("rr_3", 32'(order[3]), 32'h2);
      chk("rr_bank1", bank[1], 32'h11);
      chk("rr_bank2", bank[2], 32'h22);
      we = 2'b00;

      // Read reg 2 with Tick toggling: three Tick-high cycles spread over six clocks.
      start(0, 1'b0, 4'd2, 32'h0);
      wait_ack(1'b1, lat, cs_low, ce_seen, ce_cycles);
      chk("tk_lat", 32'(lat), 32'd6);
      chk("tk_ack", 32'(ack), 32'h1);
      chk("tk_rdata", rdata, 32'h22);
      chk("tk_cs_low", 32'(cs_low), 32'h04);
      req = 2'b00; Tick = 1'b1;

      // Out-of-range read: no strobes, err with zero data.
      start(1, 1'b0, 4'd9, 32'h0);
      wait_ack(1'b0, lat, cs_low, ce_seen, ce_cycles);
      chk("oor_lat", 32'(lat), 32'd3);
      chk("oor_ack", 32'(ack), 32'h2);
      chk("oor_err", 32'(err), 32'h1);
      chk("oor_rdata", rdata, 32'h0);
      chk("oor_cs", 32'(cs_low), 32'h00);
      chk("oor_ce", 32'(ce_seen), 32'h00);
      req = 2'b00;
      cyc(); #1;
      chk("oor_err_clear", 32'(err), 32'h0);

      // Read reg 1 via requester 0, leaving the pointer at requester 1.
      start(0, 1'b0, 4'd1, 32'h0);
      wait_ack(1'b0, lat, cs_low, ce_seen, ce_cycles);
      chk("r1_rdata", rdata, 32'h11);
      chk("r1_ack", 32'(ack), 32'h1);
      req = 2'b00;

      // Reset during RD_CAP aborts the read and returns the pointer to requester 0.
      start(1, 1'b0, 4'd2, 32'h0);
      cyc(); #1;
      chk("ab_rdsel_cs", 32'(reg_cs), 32'hFB);
      cyc(); Reset = 1'b0; #1;
      chk("ab_rdcap_cs", 32'(reg_cs), 32'hFB);
      cyc(); #1;
      chk("ab_busy", 32'(busy), 32'h0);
      chk("ab_cs", 32'(reg_cs), 32'hFF);
      chk("ab_rdata", rdata, 32'h0);
      chk("ab_ack", 32'(ack), 32'h0);
      Reset = 1'b1;
      req = 2'b11; we = 2'b00; addr0 = 4'd1; addr1 = 4'd2;
      wait_ack(1'b0, lat, cs_low, ce_seen, ce_cycles);
      chk("ab_regrant_ack", 32'(ack), 32'h1);
      chk("ab_regrant_lat", 32'(lat), 32'd3);
      chk("ab_regrant_rdata", rdata, 32'h11);
      req = 2'b00;
      repeat (2) cyc();

      chk("invariants", 32'(inv_bad), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
